rgbw_frame_sched: RTL

- Frame scheduler that sequences the LED output path.
- On a start pulse or a periodic refresh tick, it reads NUM pixel words from a synchronous pixel RAM and writes them, in address order, into the write port of the async_fifo that feeds rgb_sotp.
- It obeys FIFO full back-pressure, queues one pending trigger, and reports frame completion and overrun.

---
 rtl/rgbw_frame_sched.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rgbw_frame_sched.sv
// Frame scheduler: on a start pulse or refresh tick, streams NUM pixel-RAM words into the
// LED FIFO in address order, honouring FIFO-full back-pressure and queueing one trigger.
module rgbw_frame_sched #(
  parameter int DATA_SIZE      = 32,
  parameter int PIX_ADDR_SIZE  = 8,
  parameter int REFRESH_CYCLES = 960000,
  parameter int CNT_SIZE       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_enable,
  input  logic                     in_start,
  input  logic [PIX_ADDR_SIZE:0]   in_num_leds,
  output logic                     out_pix_rd_en,
  output logic [PIX_ADDR_SIZE-1:0] out_pix_addr,
  input  logic [DATA_SIZE-1:0]     in_pix_data,
  output logic [DATA_SIZE-1:0]     out_fifo_w_data,
  output logic                     out_fifo_w_en,
  input  logic                     in_fifo_w_full,
  output logic                     out_busy,
  output logic                     out_frame_done,
  output logic                     out_frame_overrun,
  output logic [CNT_SIZE-1:0]      out_frame_cnt
);
  localparam int TW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [PIX_ADDR_SIZE:0] MAX_NUM = {1'b1, {PIX_ADDR_SIZE{1'b0}}};

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                 state;
  logic [TW-1:0]          timer;
  logic                   tick, trig, launch, pending, wr_first;
  logic [PIX_ADDR_SIZE:0] num, idx, num_clamp;
  logic [DATA_SIZE-1:0]   data_q;

  assign tick      = in_enable && (timer == TW'(REFRESH_CYCLES - 1));
  assign trig      = in_start | tick;
  assign num_clamp = (in_num_leds > MAX_NUM) ? MAX_NUM : in_num_leds;
  assign launch    = ((state == IDLE) && trig) || ((state == DONE) && (pending || trig));

  // The RAM word lands the cycle after the read strobe, so on WR entry it flows straight
  // to the FIFO and is parked in data_q for any full-stall cycles that follow.
  assign out_fifo_w_data   = wr_first ? in_pix_data : data_q;
  // Write enable gated by the live full flag so a write can never coincide with full.
  assign out_fifo_w_en     = (state == WR) && !in_fifo_w_full;
  assign out_busy          = (state != IDLE);
  assign out_frame_done    = (state == DONE);
  assign out_frame_overrun = trig && pending && ((state == RD) || (state == WR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (!in_enable || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pending       <= 1'b0;
      wr_first      <= 1'b0;
      num           <= '0;
      idx           <= '0;
      data_q        <= '0;
      out_pix_rd_en <= 1'b0;
      out_pix_addr  <= '0;
      out_frame_cnt <= '0;
    end else begin
      out_pix_rd_en <= 1'b0;
      if (state == WR) wr_first <= 1'b0;
      if (wr_first)    data_q   <= in_pix_data;

      if ((state == RD || state == WR) && trig && !pending) pending <= 1'b1;
      else if (state == DONE)                                pending <= pending && trig;

      if (launch) begin
        num <= num_clamp;
        idx <= '0;
        if (num_clamp == '0) begin
          state         <= DONE;
          out_frame_cnt <= out_frame_cnt + 1'b1;
        end else begin
          state <= RD;
          if (!in_fifo_w_full) begin
            out_pix_rd_en <= 1'b1;
            out_pix_addr  <= '0;
          end
        end
      end else begin
        case (state)
          IDLE: ;
          RD: begin
            // A read already on the bus moves us on; otherwise retry once full drops.
            if (out_pix_rd_en) begin
              state    <= WR;
              wr_first <= 1'b1;
            end else if (!in_fifo_w_full) begin
              out_pix_rd_en <= 1'b1;
              out_pix_addr  <= idx[PIX_ADDR_SIZE-1:0];
            end
          end
          WR: begin
            if (!in_fifo_w_full) begin
              idx <= idx + 1'b1;
              if (idx == num - 1'b1) begin
                state         <= DONE;
                out_frame_cnt <= out_frame_cnt + 1'b1;
              end else begin
                state         <= RD;
                out_pix_rd_en <= 1'b1;
                out_pix_addr  <= idx[PIX_ADDR_SIZE-1:0] + 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
